restoring_divider: RTL and testbench

//  Sequential unsigned shift-subtract (restoring) divider; inverse companion to the shift-add multiplier.

---
 rtl/restoring_divider.sv | 131 +++++++++++++
 tb/tb_restoring_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock after a Run rising edge.
// Results are registered and held until the next accepted start.
module restoring_divider #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Run,
  input  logic [W-1:0] Dividend,
  input  logic [W-1:0] Divisor,
  output logic [W-1:0] Quotient,
  output logic [W-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The top bit of the partial remainder is always clear after a step, so only W bits are kept.
  typedef struct packed {
    logic [W-1:0] rem;
    logic [W-1:0] quo;
  } step_t;

  // One restoring step: shift the next dividend bit in, subtract the divisor when it fits.
  function automatic step_t div_step(input logic [W-1:0] r,
                                     input logic [W-1:0] q,
                                     input logic [W-1:0] d);
    logic [W:0] t;
    step_t      s;
    t     = {r, q[W-1]};
    s.quo = {q[W-2:0], 1'b0};
    if (t >= {1'b0, d}) begin
      s.rem    = t[W-1:0] - d;
      s.quo[0] = 1'b1;
    end else begin
      s.rem    = t[W-1:0];
    end
    return s;
  endfunction

  state_t        state_r;
  logic          run_q_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  q_work_r;
  logic [W-1:0]  r_work_r;
  logic [W-1:0]  d_work_r;
  logic          start_s;
  step_t         step_s;

  assign start_s = Run & ~run_q_r;

  // Next partial remainder/quotient from the current working registers.
  always_comb begin
    step_s = div_step(r_work_r, q_work_r, d_work_r);
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      run_q_r   <= 1'b0;
      count_r   <= '0;
      q_work_r  <= '0;
      r_work_r  <= '0;
      d_work_r  <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      run_q_r <= Run;
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            if (Divisor != '0) begin
              q_work_r  <= Dividend;
              d_work_r  <= Divisor;
              r_work_r  <= '0;
              count_r   <= '0;
              Done      <= 1'b0;
              DivByZero <= 1'b0;
              Busy      <= 1'b1;
              state_r   <= CALC;
            end else begin
              // Divide by zero resolves immediately with a saturated quotient.
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              Busy      <= 1'b0;
              state_r   <= DONE;
            end
          end else begin
            state_r <= state_r;
          end
        end
        CALC: begin
          q_work_r <= step_s.quo;
          r_work_r <= step_s.rem;
          count_r  <= count_r + CW'(1);
          if (count_r == LAST_CNT) begin
            Quotient  <= step_s.quo;
            Remainder <= step_s.rem;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r   <= CALC;
          end
        end
        default: begin
          state_r   <= IDLE;
          Busy      <= 1'b0;
          Done      <= 1'b0;
          DivByZero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (W=8): latency, hold, div-by-zero, ignored restart, reset.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         run;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors;
  int miscompares;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  restoring_divider #(.W(W)) dut (
    .Clk       (clk),
    .Reset_n   (reset_n),
    .Run       (run),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full division: checks Busy for W cycles, held outputs during CALC, result and no rerun while Run stays high.
  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
    run = 1'b0;
    tick();
    dividend = n;
    divisor  = d;
    run      = 1'b1;
    tick();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_hold_q", {24'd0, quotient}, {24'd0, last_q});
    for (int i = 1; i < W; i++) begin
      tick();
      check("calc_busy", {31'd0, busy}, 32'd1);
      check("calc_done", {31'd0, done}, 32'd0);
    end
    check("calc_hold_r", {24'd0, remainder}, {24'd0, last_r});
    tick();
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_q", {24'd0, quotient}, {24'd0, eq});
    check("end_r", {24'd0, remainder}, {24'd0, er});
    check("end_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    tick();
    check("held_busy", {31'd0, busy}, 32'd0);
    check("held_done", {31'd0, done}, 32'd1);
    check("held_q", {24'd0, quotient}, {24'd0, eq});
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_q      = '0;
    last_r      = '0;
    reset_n     = 1'b0;
    run         = 1'b0;
    dividend    = '0;
    divisor     = '0;
    tick();
    tick();
    check("rst_q", {24'd0, quotient}, 32'd0);
    check("rst_r", {24'd0, remainder}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_div(8'd200, 8'd7, 8'd28, 8'd4);
    // Back-to-back start straight out of DONE.
    run_div(8'd255, 8'd16, 8'd15, 8'd15);
    run_div(8'd7, 8'd200, 8'd0, 8'd7);
    run_div(8'd255, 8'd1, 8'd255, 8'd0);

    // Divide by zero.
    run = 1'b0;
    tick();
    dividend = 8'd100;
    divisor  = 8'd0;
    run      = 1'b1;
    tick();
    check("dbz_done", {31'd0, done}, 32'd1);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    check("dbz_q", {24'd0, quotient}, 32'd255);
    check("dbz_r", {24'd0, remainder}, 32'd100);
    check("dbz_busy", {31'd0, busy}, 32'd0);
    tick();
    check("dbz_busy2", {31'd0, busy}, 32'd0);
    last_q = 8'd255;
    last_r = 8'd100;
    run_div(8'd255, 8'd255, 8'd1, 8'd0);

    // Restart attempt mid-calculation with new operands is ignored.
    run = 1'b0;
    tick();
    dividend = 8'd200;
    divisor  = 8'd7;
    run      = 1'b1;
    tick();
    tick();
    tick();
    run      = 1'b0;
    dividend = 8'd9;
    divisor  = 8'd2;
    tick();
    run = 1'b1;
    tick();
    repeat (3) tick();
    check("ign_busy", {31'd0, busy}, 32'd1);
    tick();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_q", {24'd0, quotient}, 32'd28);
    check("ign_r", {24'd0, remainder}, 32'd4);
    last_q = 8'd28;
    last_r = 8'd4;

    // Reset during CALC clears everything immediately.
    run = 1'b0;
    tick();
    dividend = 8'd200;
    divisor  = 8'd7;
    run      = 1'b1;
    tick();
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("mrst_q", {24'd0, quotient}, 32'd0);
    check("mrst_r", {24'd0, remainder}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    last_q = '0;
    last_r = '0;
    run_div(8'd9, 8'd2, 8'd4, 8'd1);

    // Run already high when reset releases counts as one start.
    reset_n  = 1'b0;
    run      = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    tick();
    reset_n = 1'b1;
    tick();
    check("rel_busy", {31'd0, busy}, 32'd1);
    repeat (W - 1) tick();
    check("rel_busy_last", {31'd0, busy}, 32'd1);
    tick();
    check("rel_done", {31'd0, done}, 32'd1);
    check("rel_q", {24'd0, quotient}, 32'd10);
    check("rel_r", {24'd0, remainder}, 32'd0);
    last_q = 8'd10;
    last_r = 8'd0;

    run_div(8'd0, 8'd5, 8'd0, 8'd0);
    run_div(8'd254, 8'd255, 8'd0, 8'd254);
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] n;
      logic [W-1:0] d;
      n = W'($urandom_range(0, 255));
      d = W'($urandom_range(1, 255));
      run_div(n, d, n / d, n % d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
